seq_alu: RTL and testbench



---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_divider.sv | 60 ++++++
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: opcode and FSM state encodings plus opcode classification helpers.
// Optional divider support is selected in seq_alu by the SEQ_ALU_DIV_EN macro.
package seq_alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_MUL = 3'd1,
        OP_MOD = 3'd2,
        OP_AND = 3'd3,
        OP_SUB = 3'd4,
        OP_DIV = 3'd5,
        OP_OR  = 3'd6,
        OP_XOR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    function automatic logic is_multicycle(alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_divide(alu_op_e op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// Iterative restoring divider, one quotient bit per cycle for WIDTH cycles after start.
// done is high during the final iteration; quotient/remainder are valid in that same cycle.
module seq_alu_divider #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   shifted, trial;
    logic             ge;
    logic [WIDTH-1:0] rem_next, quo_next;

    // Bring the next dividend bit into the partial remainder and try the subtraction.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign ge       = (shifted >= {1'b0, dvs_q});
    assign trial    = shifted - {1'b0, dvs_q};
    assign rem_next = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], ge};

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake: 1-cycle logic/arith ops, iterative MUL/DIV/MOD.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise DIV/MOD return 0 with err set.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [OP_W-1:0]    op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    localparam int unsigned RW = 2 * WIDTH;

    alu_state_e       state_q, state_d;
    alu_op_e          op_in, op_q, op_d;
    logic             accept, go_busy;
    logic [RW-1:0]    result_q, result_d;
    logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d;
    logic [RW-1:0]    acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    assign op_in     = alu_op_e'(op);
    // Gate with rst so nothing is accepted in the reset cycle even if already idle.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = a - b;
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef SEQ_ALU_DIV_EN
    logic             div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quot, div_rem;

    assign div_start = accept && is_divide(op_in) && (b != '0);
    assign go_busy   = is_multicycle(op_in) && !(is_divide(op_in) && (b == '0));

    seq_alu_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );
`else
    assign go_busy = (op_in == OP_MUL);
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        err_d     = err_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        mul_cnt_d = mul_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = op_in;
                    result_d = '0;
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                    unique case (op_in)
                        OP_ADD: begin
                            result_d = RW'(sum[WIDTH-1:0]);
                            carry_d  = sum[WIDTH];
                        end
                        OP_SUB: begin
                            result_d = RW'(diff);
                            carry_d  = (a < b);
                        end
                        OP_AND: result_d = RW'(a & b);
                        OP_OR:  result_d = RW'(a | b);
                        OP_XOR: result_d = RW'(a ^ b);
                        OP_MUL: begin
                            acc_d     = '0;
                            mcand_d   = RW'(a);
                            mplier_d  = b;
                            mul_cnt_d = '0;
                        end
                        OP_DIV, OP_MOD: begin
`ifdef SEQ_ALU_DIV_EN
                            if (b == '0) begin
                                err_d    = 1'b1;
                                result_d = (op_in == OP_DIV) ? RW'({WIDTH{1'b1}}) : RW'(a);
                            end
`else
                            err_d = 1'b1;
`endif
                        end
                        default: result_d = '0;
                    endcase
                    state_d = go_busy ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    acc_d     = acc_step;
                    mcand_d   = mcand_q << 1;
                    mplier_d  = mplier_q >> 1;
                    mul_cnt_d = mul_cnt_q + CNT_W'(1);
                    if (mul_cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = acc_step;
                        state_d  = DONE;
                    end
                end else begin
`ifdef SEQ_ALU_DIV_EN
                    if (div_done) begin
                        result_d = (op_q == OP_DIV) ? RW'(div_quot) : RW'(div_rem);
                        state_d  = DONE;
                    end else if (!div_busy) begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags are frozen with the result on entry to DONE.
        if (state_d == DONE && state_q != DONE) begin
            zero_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_ADD;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=4 with a scoreboard of expected results.
// Expectations follow the SEQ_ALU_DIV_EN setting used for the build.
module tb_seq_alu;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready, out_valid, out_ready;
    logic           carry, zero, err;
    logic [W-1:0]   a, b;
    logic [2:0]     op;
    logic [2*W-1:0] result;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [2*W-1:0] res;
        logic           carry;
        logic           zero;
        logic           err;
        int             lat;
    } exp_t;

    exp_t sb[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int unsigned x, int unsigned y, logic [2:0] o);
        exp_t e;
        int unsigned r;
        e.carry = 1'b0;
        e.err   = 1'b0;
        e.lat   = 1;
        r       = 0;
        case (o)
            3'd0: begin r = (x + y) % 16; e.carry = (x + y) > 15; end
            3'd1: begin r = x * y; e.lat = W + 1; end
            3'd2, 3'd5: begin
`ifdef SEQ_ALU_DIV_EN
                if (y == 0) begin
                    e.err = 1'b1;
                    r = (o == 3'd5) ? 15 : x;
                end else begin
                    r = (o == 3'd5) ? x / y : x % y;
                    e.lat = W + 1;
                end
`else
                e.err = 1'b1;
                r = 0;
`endif
            end
            3'd3: r = x & y;
            3'd4: begin r = (x + 16 - y) % 16; e.carry = (x < y); end
            3'd6: r = x | y;
            default: r = x ^ y;
        endcase
        e.res  = r[2*W-1:0];
        e.zero = (r == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [2:0] xo, input int hold);
        exp_t e;
        int   lat;
        sb.push_back(model(xa, xb, xo));
        check("in_ready_idle", in_ready, 1);
        a = xa; b = xb; op = xo; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~xa; b = ~xb; op = xo + 3'd1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        e = sb.pop_front();
        check("out_valid", out_valid, 1);
        check("latency", lat, e.lat);
        check("result", result, e.res);
        check("carry", carry, e.carry);
        check("zero", zero, e.zero);
        check("err", err, e.err);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 3'd0;
            step();
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, e.res);
            check("bp_flags", {carry, zero, err}, {e.carry, e.zero, e.err});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("handoff_valid", out_valid, 0);
        check("handoff_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry, zero, err}, 3'b000);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        run_op(4'd5, 4'd3, 3'd0, 0);    // ADD -> 8
        run_op(4'd5, 4'd3, 3'd3, 0);    // AND -> 1
        run_op(4'd5, 4'd3, 3'd4, 0);    // SUB -> 2
        run_op(4'd3, 4'd5, 3'd4, 0);    // SUB borrow -> 14
        run_op(4'd5, 4'd3, 3'd1, 0);    // MUL -> 15
        run_op(4'd15, 4'd15, 3'd1, 0);  // MUL max -> 225
        run_op(4'd5, 4'd3, 3'd2, 0);    // Modulo
        run_op(4'd5, 4'd3, 3'd5, 0);    // DIV
        run_op(4'd7, 4'd0, 3'd5, 0);    // DIV by zero
        run_op(4'd7, 4'd0, 3'd2, 0);    // Modulo by zero
        run_op(4'd15, 4'd15, 3'd0, 0);  // ADD max, carry
        run_op(4'd15, 4'd1, 3'd0, 0);   // ADD wraps to zero
        run_op(4'd9, 4'd9, 3'd7, 0);    // XOR -> zero
        run_op(4'd10, 4'd5, 3'd6, 0);   // OR -> 15
        run_op(4'd0, 4'd13, 3'd1, 0);   // MUL by zero

        // Backpressure on a MUL; in_valid held high meanwhile must not be queued.
        run_op(4'd5, 4'd3, 3'd1, 10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_queued", out_valid, 0);
        end

        // Reset two cycles into a MUL aborts it.
        a = 4'd5; b = 4'd3; op = 3'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("abort_no_out", out_valid, 0);
        end
        run_op(4'd5, 4'd3, 3'd0, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
